uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
- Parametrised successor to the team's single-word UART transmitter.
- Buffers up to FIFO_DEPTH words loaded by the host and serialises them LSB-first on one line.
- Frame format is configurable in data width, bit period and stop bits.
- Sits between the RLS result/readout logic and the board UART pin; one `start` drains the whole queue back-to-back.

Parameters:
- CLK_DIV, 434, clock cycles per serial bit (434 gives 115200 baud at 50 MHz); legal range >= 2
- DATA_W, 8, data bits per frame; legal range 5..16
- FIFO_DEPTH, 4, transmit buffer depth; power of two, >= 2
- STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- load  input  1  push din into FIFO (single-cycle strobe)
- din  input  DATA_W  word to queue
- start  input  1  begin draining FIFO (single-cycle strobe)
- serialo  output  1  serial line, idle high
- busy  output  1  frame in progress or drain armed
- full  output  1  FIFO holds FIFO_DEPTH words
- empty  output  1  FIFO holds 0 words
- count  output  $clog2(FIFO_DEPTH)+1  words queued
- overflow  output  1  sticky: load attempted while full

Behaviour:
- Reset (reset==0 at a rising edge) takes effect at that edge, including mid-frame:
  - serialo=1, busy=0, full=0, empty=1, count=0, overflow=0
  - FIFO pointers cleared, state=IDLE, bit counter and divider cleared
- FIFO push:
  - load=1 and count<FIFO_DEPTH stores din at the write pointer; count+1 next cycle.
  - load=1 while full drops the word and sets overflow (held until reset).
- FIFO pop:
  - Occurs on the cycle the FSM leaves IDLE or STOP for START.
  - Simultaneous push and pop leaves count unchanged; both operations succeed.
  - `full` is evaluated on the registered count, so a push in the pop cycle of a full FIFO is dropped.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PAR (only with PARITY_EN), STOP.
  - IDLE: serialo=1. If start=1 and empty=0 -> START next cycle; pop the word into the shift register; busy=1. If start=1 and empty=1, start is ignored and busy stays 0.
  - START: serialo=0 for CLK_DIV cycles -> DATA.
  - DATA: serialo=shift[0] for CLK_DIV cycles per bit, LSB first; shift right; after DATA_W bits -> PAR or STOP.
  - STOP: serialo=1 for STOP_BITS*CLK_DIV cycles. Then -> START (with pop) if FIFO non-empty, else IDLE with busy=0.
- start while busy=1 is ignored; loads during a drain join the current burst.
- Latency: serialo falls at the edge after the one sampling start; no idle gap between consecutive frames.
- Frame length: (1 + DATA_W + P + STOP_BITS)*CLK_DIV cycles, where P=1 with PARITY_EN, else 0.
- Divider counts 0..CLK_DIV-1 and reloads at each bit boundary; no accumulated drift.
- busy falls on the same edge serialo returns to IDLE after the final stop bit.

Optional Feature:
- Macro: UART_TX_PARITY_EN
- Defined: PAR state inserted after DATA. serialo = XOR of the DATA_W data bits (even parity) for CLK_DIV cycles.
- Undefined: no PAR state, no parity logic; DATA goes directly to STOP.

Test Plan:
- CLK_DIV=4, DATA_W=8, no parity:
  - pulse reset low 2 cycles, load 0xA5, pulse start -> serialo sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); busy high exactly 40 cycles; empty=1 at end.
- Load 0x01,0x02,0x03 then one start -> three frames back-to-back, no idle cycle between stop and next start bit; count steps 3->2->1->0 at each frame start.
- Overflow:
  - Load 5 words with FIFO_DEPTH=4 -> full=1 after the 4th; 5th dropped; overflow=1.
  - Transmission sends only the first 4 words; overflow stays 1 until reset.
- Reset mid-frame:
  - Assert reset during DATA bit 3 -> serialo=1, busy=0, count=0 on the next edge.
  - A later load 0x3C + start sends a clean complete frame.
- STOP_BITS=2 with UART_TX_PARITY_EN defined, send 0x07 -> data bits 1,1,1,0,0,0,0,0; parity bit 1; stop high 8 cycles; frame length 48 cycles.
- start with empty FIFO -> serialo stays 1, busy stays 0.
- Load while full and popping in the same cycle -> word dropped, overflow=1, count decrements by 1.

Source files
------------

// File: rtl/uart_tx_param.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | uart_tx_param : FIFO-buffered UART transmitter, one start drains the queue.   |
// | Optional macro UART_TX_PARITY_EN adds an even-parity bit.       Rev 1.0       |
// +-----------------------------------------------------------------------------+
module uart_tx_param #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [DATA_W-1:0]           din,
  input  logic                        start,
  output logic                        serialo,
  output logic                        busy,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [DW-1:0] C_DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] C_DIV_ONE   = DW'(1);
  localparam logic [BW-1:0] C_DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] C_STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] C_BIT_ONE   = BW'(1);
  localparam logic [AW-1:0] C_PTR_ONE   = AW'(1);
  localparam logic [AW:0]   C_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   C_DEPTH     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PAR = 3'd4
`endif
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;
  logic                r_overflow;

  logic [DW-1:0]       r_div;
  logic [BW-1:0]       r_bit;
  logic [DATA_W-1:0]   r_shift;
  logic                r_serialo;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_bit_end;
  logic                w_line;

`ifdef UART_TX_PARITY_EN
  logic                r_parity;
`endif

  assign w_full    = (r_count == C_DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_push    = load && !w_full;
  assign w_bit_end = (r_div == C_DIV_LAST);

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (load && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !w_empty) begin
          w_state_nxt = S_START;
          w_pop       = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end && (r_bit == C_DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = S_PAR;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PAR: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit so a burst has no idle gap.
        if (w_bit_end && (r_bit == C_STOP_LAST)) begin
          if (!w_empty) begin
            w_state_nxt = S_START;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      S_START: w_line = 1'b0;
      S_DATA:  w_line = r_shift[0];
`ifdef UART_TX_PARITY_EN
      S_PAR:   w_line = r_parity;
`endif
      default: w_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_serialo <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_serialo <= w_line;
      r_div     <= ((r_state == S_IDLE) || w_bit_end) ? '0 : r_div + C_DIV_ONE;
      if (w_state_nxt != r_state) begin
        r_bit <= '0;
      end else if (w_bit_end) begin
        r_bit <= r_bit + C_BIT_ONE;
      end
      if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr];
      end else if ((r_state == S_DATA) && w_bit_end) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= ^r_mem[r_rd_ptr];
    end
  end
`endif

  assign serialo  = r_serialo;
  assign busy     = (r_state != S_IDLE);
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// Directed bench for uart_tx_param: frame timing, bursts, FIFO overflow and mid-frame reset.
module tb_uart_tx_param;

  localparam int CLK_DIV    = 4;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int STOP_BITS  = 2;
  localparam int PBITS      = 1;
`else
  localparam int STOP_BITS  = 1;
  localparam int PBITS      = 0;
`endif
  localparam int FRAME = (1 + DATA_W + PBITS + STOP_BITS) * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] din;
  logic       start;
  logic       serialo;
  logic       busy;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  uart_tx_param #(
    .CLK_DIV   (CLK_DIV),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .din     (din),
    .start   (start),
    .serialo (serialo),
    .busy    (busy),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       exp_par;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] d);
    load = 1'b1;
    din  = d;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Expected line level for state cycle j of a frame carrying d.
  function automatic logic fbit(input logic [7:0] d, input logic par, input int j);
    int idx;
    idx = j / CLK_DIV;
    if (idx == 0) return 1'b0;
    if (idx <= DATA_W) return d[idx-1];
    if ((PBITS == 1) && (idx == DATA_W + 1)) return par;
    return 1'b1;
  endfunction

  // Called one cycle after the edge that popped d; serialo lags the FSM by one edge.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                           input logic last, input int cnt_after);
    for (int j = 0; j < FRAME; j++) begin
      tick();
      chk($sformatf("%s serialo[%0d]", tag, j), {31'd0, serialo}, {31'd0, fbit(d, par, j)});
      chk($sformatf("%s busy[%0d]", tag, j), {31'd0, busy},
          (last && (j == FRAME - 1)) ? 32'd0 : 32'd1);
    end
    chk($sformatf("%s count_after", tag), {29'd0, count}, cnt_after);
  endtask

  initial begin
    vecs[0] = '{din: 8'hA5, exp_par: 1'b0};
    vecs[1] = '{din: 8'h3C, exp_par: 1'b0};
    vecs[2] = '{din: 8'h00, exp_par: 1'b0};
    vecs[3] = '{din: 8'hFF, exp_par: 1'b0};
    vecs[4] = '{din: 8'h07, exp_par: 1'b1};
    vecs[5] = '{din: 8'h80, exp_par: 1'b1};
    vecs[6] = '{din: 8'h81, exp_par: 1'b0};

    reset = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    din   = 8'h00;
    tick();
    tick();
    chk("rst serialo",  {31'd0, serialo},  1);
    chk("rst busy",     {31'd0, busy},     0);
    chk("rst full",     {31'd0, full},     0);
    chk("rst empty",    {31'd0, empty},    1);
    chk("rst count",    {29'd0, count},    0);
    chk("rst overflow", {31'd0, overflow}, 0);
    reset = 1'b1;

    // Single frames from the table
    for (int v = 0; v < 7; v++) begin
      load_word(vecs[v].din);
      chk($sformatf("vec%0d count_loaded", v), {29'd0, count}, 1);
      chk($sformatf("vec%0d empty_loaded", v), {31'd0, empty}, 0);
      pulse_start();
      chk($sformatf("vec%0d busy_start", v),    {31'd0, busy},    1);
      chk($sformatf("vec%0d serialo_start", v), {31'd0, serialo}, 1);
      chk($sformatf("vec%0d count_popped", v),  {29'd0, count},   0);
      run_frame($sformatf("vec%0d", v), vecs[v].din, vecs[v].exp_par, 1'b1, 0);
      chk($sformatf("vec%0d empty_end", v), {31'd0, empty}, 1);
    end

    // Back-to-back burst of three
    load_word(8'h01);
    load_word(8'h02);
    load_word(8'h03);
    chk("burst count3", {29'd0, count}, 3);
    pulse_start();
    chk("burst count2", {29'd0, count}, 2);
    run_frame("burst w1", 8'h01, 1'b1, 1'b0, 1);
    run_frame("burst w2", 8'h02, 1'b1, 1'b0, 0);
    run_frame("burst w3", 8'h03, 1'b0, 1'b1, 0);

    // Overflow: fifth word dropped
    load_word(8'h10);
    load_word(8'h20);
    load_word(8'h30);
    chk("ovf full3", {31'd0, full}, 0);
    load_word(8'h40);
    chk("ovf full4",  {31'd0, full},     1);
    chk("ovf count4", {29'd0, count},    4);
    chk("ovf clear4", {31'd0, overflow}, 0);
    load_word(8'h50);
    chk("ovf set",    {31'd0, overflow}, 1);
    chk("ovf count5", {29'd0, count},    4);
    pulse_start();
    run_frame("ovf w1", 8'h10, 1'b1, 1'b0, 2);
    run_frame("ovf w2", 8'h20, 1'b1, 1'b0, 1);
    run_frame("ovf w3", 8'h30, 1'b0, 1'b0, 0);
    run_frame("ovf w4", 8'h40, 1'b1, 1'b1, 0);
    chk("ovf sticky", {31'd0, overflow}, 1);
    chk("ovf empty",  {31'd0, empty},    1);

    // Start with an empty FIFO is ignored
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("empty_start serialo[%0d]", i), {31'd0, serialo}, 1);
      chk($sformatf("empty_start busy[%0d]", i),    {31'd0, busy},    0);
      tick();
    end

    // Load while full in the pop cycle: dropped, count still decrements
    do_reset();
    chk("pp overflow_cleared", {31'd0, overflow}, 0);
    load_word(8'h11);
    load_word(8'h22);
    load_word(8'h33);
    load_word(8'h44);
    chk("pp full", {31'd0, full}, 1);
    start = 1'b1;
    load  = 1'b1;
    din   = 8'h99;
    tick();
    start = 1'b0;
    load  = 1'b0;
    chk("pp count",    {29'd0, count},    3);
    chk("pp overflow", {31'd0, overflow}, 1);
    chk("pp busy",     {31'd0, busy},     1);
    run_frame("pp w1", 8'h11, 1'b0, 1'b0, 2);
    run_frame("pp w2", 8'h22, 1'b0, 1'b0, 1);
    run_frame("pp w3", 8'h33, 1'b0, 1'b0, 0);
    run_frame("pp w4", 8'h44, 1'b0, 1'b1, 0);

    // Reset in the middle of data bit 3
    load_word(8'h55);
    load_word(8'h66);
    pulse_start();
    for (int i = 0; i < 17; i++) tick();
    chk("mid busy_before",  {31'd0, busy},  1);
    chk("mid count_before", {29'd0, count}, 1);
    reset = 1'b0;
    tick();
    chk("mid serialo", {31'd0, serialo}, 1);
    chk("mid busy",    {31'd0, busy},    0);
    chk("mid count",   {29'd0, count},   0);
    chk("mid empty",   {31'd0, empty},   1);
    reset = 1'b1;
    tick();
    chk("mid idle_line", {31'd0, serialo}, 1);
    load_word(8'h3C);
    pulse_start();
    run_frame("mid 3C", 8'h3C, 1'b0, 1'b1, 0);
    chk("mid empty_end", {31'd0, empty}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
